// File: rtl/record_serializer_pkg.sv
// Shared state type and width helpers for record_serializer and its sub-modules.
package record_serializer_pkg;

  localparam int DROP_W = 16;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} rd_state_t;

  function automatic int idx_w(input int nbuf);
    return (nbuf > 1) ? $clog2(nbuf) : 1;
  endfunction

  function automatic int beat_w(input int rec_bytes, input int out_bytes);
    return $clog2(rec_bytes / out_bytes) + 1;
  endfunction

endpackage

// File: rtl/generic_sync_fifo.sv
// Show-ahead synchronous FIFO: the head word is on o_rd_data whenever !o_empty, pop takes effect next edge.
// Writes while full and reads while empty are ignored; the caller owns flow control.
module generic_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_wr_en,
  input  logic [WIDTH-1:0]       i_wr_data,
  input  logic                   i_rd_en,
  output logic [WIDTH-1:0]       o_rd_data,
  output logic                   o_empty,
  output logic                   o_full,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_push;
  logic             w_pop;

  assign w_push    = i_wr_en && !o_full;
  assign w_pop     = i_rd_en && !o_empty;
  assign o_count   = r_wptr - r_rptr;
  assign o_empty   = (r_wptr == r_rptr);
  // Pointers carry one wrap bit so full and empty stay distinguishable.
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_rd_data = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + {{AW{1'b0}}, 1'b1};
      if (w_pop)  r_rptr <= r_rptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= i_wr_data;
  end

endmodule

// File: rtl/record_serializer_shifter.sv
// Holds one record and presents it low bytes first, advancing one beat per i_shift.
// i_load has priority over i_shift; o_last marks the final beat of the record.
module record_serializer_shifter
  import record_serializer_pkg::*;
#(
  parameter int REC_BYTES = 16,
  parameter int OUT_BYTES = 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_load,
  input  logic [8*REC_BYTES-1:0] i_rec,
  input  logic                   i_shift,
  output logic [8*OUT_BYTES-1:0] o_beat,
  output logic                   o_last
);

  localparam int NBEATS = REC_BYTES / OUT_BYTES;
  localparam int BW     = beat_w(REC_BYTES, OUT_BYTES);

  logic [8*REC_BYTES-1:0] r_shift;
  logic [BW-1:0]          r_beat;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shift <= '0;
      r_beat  <= '0;
    end else if (i_load) begin
      r_shift <= i_rec;
      r_beat  <= '0;
    end else if (i_shift) begin
      r_shift <= r_shift >> (8 * OUT_BYTES);
      r_beat  <= r_beat + BW'(1);
    end
  end

  assign o_beat = r_shift[8*OUT_BYTES-1:0];
  assign o_last = (r_beat == BW'(NBEATS - 1));

endmodule

// File: rtl/record_serializer.sv
// Ring of NBUF record FIFOs; sealed buffers drain whole as OUT_BYTES beats, seal to first req in 2 cycles,
// beats held until omux_sel_i. Idle flush of partial buffers only with RECORD_SERIALIZER_FLUSH_EN defined.
module record_serializer
  import record_serializer_pkg::*;
#(
  parameter int REC_BYTES    = 16,
  parameter int OUT_BYTES    = 1,
  parameter int DEPTH        = 32,
  parameter int NBUF         = 4,
  parameter int FLUSH_CYCLES = 1024
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [8*REC_BYTES-1:0] rec_i,
  input  logic                   we_i,
  output logic                   omux_req_o,
  input  logic                   omux_sel_i,
  output logic [8*OUT_BYTES-1:0] omux_data_o,
  output logic [DROP_W-1:0]      drop_count_o,
  output logic [NBUF-1:0]        sealed_o
);

  localparam int IDX_W  = idx_w(NBUF);
  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int RW     = 8 * REC_BYTES;
  localparam int IDLE_W = $clog2(FLUSH_CYCLES + 1);

`ifdef RECORD_SERIALIZER_FLUSH_EN
  localparam bit FLUSH_EN = 1'b1;
`else
  localparam bit FLUSH_EN = 1'b0;
`endif

  rd_state_t              r_state;
  rd_state_t              w_state_nxt;
  logic [IDX_W-1:0]       r_wr_buf;
  logic [IDX_W-1:0]       r_rd_buf;
  logic [IDX_W-1:0]       w_wr_next;
  logic [IDX_W-1:0]       w_rd_next;
  logic [NBUF-1:0]        r_sealed;
  logic [NBUF-1:0]        w_sealed_nxt;
  logic [DROP_W-1:0]      r_drop_cnt;
  logic [IDLE_W-1:0]      r_idle_cnt;

  logic [RW-1:0]          w_fifo_rdata [NBUF];
  logic [CNT_W-1:0]       w_fifo_count [NBUF];
  logic [NBUF-1:0]        w_fifo_empty;
  logic [NBUF-1:0]        w_fifo_full;
  logic [NBUF-1:0]        w_fifo_wr;
  logic [NBUF-1:0]        w_fifo_rd;

  logic                   w_wr_accept;
  logic                   w_seal;
  logic                   w_idle;
  logic                   w_flush_seal;
  logic                   w_wr_advance;
  logic                   w_load;
  logic                   w_shift;
  logic                   w_release;
  logic                   w_last;
  logic                   w_req;
  logic [8*OUT_BYTES-1:0] w_beat;

  for (genvar gi = 0; gi < NBUF; gi++) begin : g_buf
    assign w_fifo_wr[gi] = w_wr_accept && (r_wr_buf == IDX_W'(gi));
    assign w_fifo_rd[gi] = w_load && (r_rd_buf == IDX_W'(gi));

    generic_sync_fifo #(
      .WIDTH (RW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .i_clk     (clk_i),
      .i_rst     (reset_i),
      .i_wr_en   (w_fifo_wr[gi]),
      .i_wr_data (rec_i),
      .i_rd_en   (w_fifo_rd[gi]),
      .o_rd_data (w_fifo_rdata[gi]),
      .o_empty   (w_fifo_empty[gi]),
      .o_full    (w_fifo_full[gi]),
      .o_count   (w_fifo_count[gi])
    );
  end

  assign w_wr_next = (r_wr_buf == IDX_W'(NBUF - 1)) ? '0 : r_wr_buf + IDX_W'(1);
  assign w_rd_next = (r_rd_buf == IDX_W'(NBUF - 1)) ? '0 : r_rd_buf + IDX_W'(1);

  assign w_wr_accept  = we_i && !r_sealed[r_wr_buf] && !w_fifo_full[r_wr_buf];
  assign w_idle       = FLUSH_EN && !we_i && !r_sealed[r_wr_buf] && !w_fifo_empty[r_wr_buf];
  assign w_flush_seal = w_idle && (r_idle_cnt == IDLE_W'(FLUSH_CYCLES - 1));
  assign w_seal       = (w_wr_accept && (w_fifo_count[r_wr_buf] == CNT_W'(DEPTH - 1))) || w_flush_seal;

  // The advance decision looks at post-clear/post-seal flags so a drained buffer can be reused at once.
  always_comb begin
    w_sealed_nxt = r_sealed;
    if (w_release) w_sealed_nxt[r_rd_buf] = 1'b0;
    if (w_seal)    w_sealed_nxt[r_wr_buf] = 1'b1;
    w_wr_advance = w_sealed_nxt[r_wr_buf] && !w_sealed_nxt[w_wr_next] && w_fifo_empty[w_wr_next];
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_release   = 1'b0;
    w_req       = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_sealed[r_rd_buf]) w_state_nxt = LOAD;
      end
      LOAD: begin
        w_load      = 1'b1;
        w_state_nxt = SHIFT;
      end
      SHIFT: begin
        w_req = 1'b1;
        if (omux_sel_i) begin
          w_shift = 1'b1;
          if (w_last) begin
            if (!w_fifo_empty[r_rd_buf]) begin
              w_state_nxt = LOAD;
            end else begin
              w_release   = 1'b1;
              w_state_nxt = IDLE;
            end
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_wr_buf   <= '0;
      r_rd_buf   <= '0;
      r_sealed   <= '0;
      r_drop_cnt <= '0;
      r_idle_cnt <= '0;
    end else begin
      r_sealed <= w_sealed_nxt;
      if (w_wr_advance) r_wr_buf <= w_wr_next;
      if (w_release)    r_rd_buf <= w_rd_next;
      if (we_i && !w_wr_accept && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + DROP_W'(1);
      if (we_i || w_flush_seal) r_idle_cnt <= '0;
      else if (w_idle)          r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
    end
  end

  record_serializer_shifter #(
    .REC_BYTES (REC_BYTES),
    .OUT_BYTES (OUT_BYTES)
  ) u_shifter (
    .i_clk   (clk_i),
    .i_rst   (reset_i),
    .i_load  (w_load),
    .i_rec   (w_fifo_rdata[r_rd_buf]),
    .i_shift (w_shift),
    .o_beat  (w_beat),
    .o_last  (w_last)
  );

  assign omux_req_o   = w_req;
  assign omux_data_o  = omux_sel_i ? w_beat : '0;
  assign drop_count_o = r_drop_cnt;
  assign sealed_o     = r_sealed;

endmodule
